mem_port: RTL and testbench

Memory-port sequencer sitting directly downstream of the multi-cycle controller and datapath address mux. It turns a single-cycle memory request (fetch, load or store) into a req/gnt/rvalid bus transaction to a variable-latency memory. It drives byte enables, formats load data, and raises `Stall` so the controller holds its current state until the access completes. It also detects misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_port_pkg.sv | 60 ++++++
 rtl/mem_port_load_formatter.sv | 42 ++++
 rtl/mem_port.sv | 161 ++++++++++++++++
 tb/tb_mem_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types, funct3 encodings and access-decode helpers for the memory port.
package mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] calc_be(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] adr_lo);
    logic [3:0] be_v;
    if (!is_store) begin
      be_v = 4'b1111;
    end else begin
      case (f3)
        F3_B:    be_v = 4'b0001 << adr_lo;
        F3_H:    be_v = 4'b0011 << adr_lo;
        default: be_v = 4'b1111;
      endcase
    end
    return be_v;
  endfunction

  // Legal funct3 for the direction, and address aligned to the access size.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] adr_lo);
    logic legal_v;
    logic aligned_v;
    case (f3)
      F3_B, F3_H, F3_W: legal_v = 1'b1;
      F3_BU, F3_HU:     legal_v = ~is_store;
      default:          legal_v = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   aligned_v = 1'b1;
      2'b01:   aligned_v = ~adr_lo[0];
      default: aligned_v = (adr_lo == 2'b00);
    endcase
    return legal_v & aligned_v;
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] wd_v;
    case (f3)
      F3_B:    wd_v = {4{wd[7:0]}};
      F3_H:    wd_v = {2{wd[15:0]}};
      default: wd_v = wd;
    endcase
    return wd_v;
  endfunction

endpackage

// File: rtl/mem_port_load_formatter.sv
// Load data lane select plus sign/zero extension.
module load_formatter
  import mem_port_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    byte_s = 8'd0;
    case (adr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (adr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane to a full word.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_BU:   data = {24'd0, byte_s};
      F3_HU:   data = {16'd0, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Memory-port sequencer: turns a controller memory request into a req/gnt/rvalid
// bus transaction, stalling the controller until the access completes.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        IsFetch,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        RespValid,
  output logic        Misalign,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       f3_r;
  logic [1:0]       adr_lo_r;
  logic             mem_req_r, mem_we_r, resp_valid_r, misalign_r, bus_err_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, read_data_r, fmt_data_s;
  logic [3:0]       mem_be_r;
  logic [2:0]       eff_f3_s;
  logic             is_store_s, accept_s, ok_s, timeout_s, abort_s, stall_s;

  // A fetch is always a word read regardless of funct3/MemWrite.
  assign eff_f3_s   = IsFetch ? F3_W : funct3;
  assign is_store_s = MemWrite & ~IsFetch;
  assign accept_s   = (state_r == ST_IDLE) & MemReq;
  assign ok_s       = access_ok(is_store_s, eff_f3_s, Adr[1:0]);
  assign timeout_s  = (cnt_r >= CNT_W'(TIMEOUT - 1));
  // Bus event wins over the timeout in the same cycle.
  assign abort_s    = timeout_s & (((state_r == ST_REQ) & ~mem_gnt) |
                                   ((state_r == ST_WAIT_R) & ~mem_rvalid));

  load_formatter u_fmt (
    .funct3 (f3_r),
    .adr_lo (adr_lo_r),
    .rdata  (mem_rdata),
    .data   (fmt_data_s)
  );

  // Next-state and stall decode.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MemReq) begin
          stall_s = 1'b1;
          state_s = ok_s ? ST_REQ : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (mem_gnt) begin
          state_s = mem_we_r ? ST_DONE : ST_WAIT_R;
        end else if (timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        stall_s = 1'b1;
        if (mem_rvalid || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT_R;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, timeout counter, response flags and load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      resp_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
      bus_err_r    <= 1'b0;
      read_data_r  <= 32'd0;
    end else begin
      state_r      <= state_s;
      resp_valid_r <= (state_s == ST_DONE);
      misalign_r   <= accept_s & ~ok_s;
      bus_err_r    <= abort_s;
      if (accept_s) begin
        cnt_r <= '0;
      end else if ((state_r == ST_REQ) || (state_r == ST_WAIT_R)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if ((state_r == ST_WAIT_R) && mem_rvalid) begin
        read_data_r <= fmt_data_s;
      end else begin
        read_data_r <= read_data_r;
      end
    end
  end

  // Bus request registers, loaded once per accepted legal access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      f3_r        <= 3'd0;
      adr_lo_r    <= 2'd0;
    end else if (accept_s && ok_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= is_store_s;
      mem_addr_r  <= {Adr[31:2], 2'b00};
      mem_be_r    <= calc_be(is_store_s, eff_f3_s, Adr[1:0]);
      mem_wdata_r <= replicate_wdata(eff_f3_s, WriteData);
      f3_r        <= eff_f3_s;
      adr_lo_r    <= Adr[1:0];
    end else if ((state_r == ST_REQ) && (mem_gnt || timeout_s)) begin
      mem_req_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_r;
    end
  end

  assign Stall     = stall_s;
  assign ReadData  = read_data_r;
  assign RespValid = resp_valid_r;
  assign Misalign  = misalign_r;
  assign BusErr    = bus_err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases plus randomized accesses
// compared against a per-access reference model of cycle counts and data.
module tb_mem_port;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, IsFetch, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Adr, WriteData;
  logic        Stall, RespValid, Misalign, BusErr;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  mem_port #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .IsFetch(IsFetch), .MemWrite(MemWrite),
    .funct3(funct3), .Adr(Adr), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData),
    .RespValid(RespValid), .Misalign(Misalign), .BusErr(BusErr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Access width in bytes; 0 means the funct3 is illegal for this direction.
  function automatic int nbytes(input bit fetch, input bit st, input logic [2:0] f3);
    if (fetch) return 4;
    if (st) begin
      case (f3)
        3'd0: return 1;
        3'd1: return 2;
        3'd2: return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input bit fetch, input logic [2:0] f3,
                                           input logic [1:0] off, input logic [31:0] rdata);
    int n;
    logic [63:0] v;
    n = nbytes(fetch, 1'b0, f3);
    v = {32'd0, rdata >> (8 * int'(off))};
    v = v & ((64'd1 << (8 * n)) - 64'd1);
    if (!fetch && (f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input int n, input logic [1:0] off);
    logic [7:0] m;
    if (!st) return 4'hF;
    m = ((8'd1 << n) - 8'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  // One access: gnt_dly wait cycles before grant (>=T means never), rv_dly before rvalid.
  task automatic do_access(input bit fetch, input bit we, input logic [2:0] f3,
                           input logic [31:0] adr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    int n, d, gnt_c, rv_c, lreq;
    bit ok, st, tmo;
    logic [31:0] exp_rd;
    st = we && !fetch;
    n = nbytes(fetch, st, f3);
    ok = 1'b0;
    if (n != 0) ok = ((int'(adr[1:0]) % n) == 0);
    tmo = 1'b0; gnt_c = 0; rv_c = -1; lreq = 0;
    if (!ok) begin
      d = 1;
    end else if (gnt_dly >= T) begin
      tmo = 1'b1; d = T + 1; gnt_c = 1000; lreq = T;
    end else begin
      gnt_c = 1 + gnt_dly; lreq = gnt_c;
      if (st) d = gnt_c + 1;
      else if (gnt_dly + rv_dly + 2 > T) begin tmo = 1'b1; d = T + 1; end
      else begin rv_c = gnt_c + 1 + rv_dly; d = rv_c + 1; end
    end
    exp_rd = (ok && !st && !tmo) ? exp_load(fetch, f3, adr[1:0], rdata) : rd_model;

    @(posedge clk); #1;
    MemReq = 1'b1; IsFetch = fetch; MemWrite = we; funct3 = f3; Adr = adr; WriteData = wd;
    for (int c = 0; c <= d; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      mem_gnt    = (c == gnt_c) || ((c == 0 || c > gnt_c) && $urandom_range(1) == 1);
      mem_rvalid = (c == rv_c) || (c <= gnt_c && $urandom_range(1) == 1);
      mem_rdata  = (c == rv_c) ? rdata : $urandom();
      @(negedge clk);
      chk1("stall", Stall, c < d);
      chk1("resp_valid", RespValid, c == d);
      chk1("mem_req", mem_req, ok && c >= 1 && c <= lreq);
      if (ok && c == 1) begin
        chk("mem_addr", mem_addr, adr & 32'hFFFF_FFFC);
        chk("mem_be", 32'(mem_be), 32'(exp_be(st, n, adr[1:0])));
        chk1("mem_we", mem_we, st);
        if (st) chk("mem_wdata", mem_wdata, exp_wdata(wd, n));
      end
      if (c == d) begin
        chk1("misalign", Misalign, !ok);
        chk1("bus_err", BusErr, tmo);
        chk("read_data", ReadData, exp_rd);
      end
    end
    rd_model = exp_rd;
    @(posedge clk); #1;
    MemReq = 1'b0;
    mem_gnt = 1'($urandom_range(1));
    mem_rvalid = 1'b1;
    mem_rdata = $urandom();
    @(negedge clk);
    chk1("idle_stall", Stall, 1'b0);
    chk("idle_read_data", ReadData, rd_model);
  endtask

  // Abort a fetch with reset in REQ (at=1) or WAIT_R (at=2), then run a fresh fetch.
  task automatic reset_mid(input int at);
    @(posedge clk); #1;
    MemReq = 1'b1; IsFetch = 1'b1; MemWrite = 1'b0; funct3 = 3'd0; Adr = 32'h300;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 1; c <= at; c++) begin
      @(posedge clk); #1;
      mem_gnt = (c == 1 && at == 2);
    end
    @(negedge clk);
    chk1("pre_rst_stall", Stall, 1'b1);
    chk1("pre_rst_mem_req", mem_req, at == 1);
    MemReq = 1'b0; reset = 1'b0;
    #1;
    chk1("rst_stall", Stall, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_resp_valid", RespValid, 1'b0);
    chk("rst_read_data", ReadData, 32'd0);
    rd_model = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1; mem_gnt = 1'b0;
    do_access(1'b1, 1'b0, 3'd0, 32'h0000_0400, 32'd0, 32'hCAFE_0001, 0, 0);
  endtask

  initial begin
    bit fetch, we;
    int kind, gd, rv;
    logic [2:0] f3;
    logic [31:0] a;

    reset = 1'b0; MemReq = 1'b1; IsFetch = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
    Adr = 32'd0; WriteData = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    rd_model = 32'd0;
    #12;
    chk1("reset_stall_follows_memreq", Stall, 1'b1);
    chk1("reset_mem_req", mem_req, 1'b0);
    chk1("reset_mem_we", mem_we, 1'b0);
    chk("reset_mem_be", 32'(mem_be), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_read_data", ReadData, 32'd0);
    chk1("reset_resp_valid", RespValid, 1'b0);
    chk1("reset_misalign", Misalign, 1'b0);
    chk1("reset_bus_err", BusErr, 1'b0);
    MemReq = 1'b0;
    #1;
    chk1("reset_stall_idle", Stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_access(1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'd0, 32'h0050_0093, 0, 0);
    do_access(1'b0, 1'b0, 3'd0, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0, 0);
    do_access(1'b0, 1'b0, 3'd4, 32'h0000_0203, 32'd0, 32'h80FF_1234, 1, 1);
    do_access(1'b0, 1'b0, 3'd5, 32'h0000_0202, 32'd0, 32'h80FF_1234, 0, 2);
    do_access(1'b0, 1'b0, 3'd1, 32'h0000_0202, 32'd0, 32'h80FF_1234, 2, 0);
    do_access(1'b0, 1'b1, 3'd1, 32'h0000_0206, 32'h1234_ABCD, 32'd0, 3, 0);
    do_access(1'b0, 1'b1, 3'd0, 32'h0000_0105, 32'h0000_00A5, 32'd0, 0, 0);
    do_access(1'b0, 1'b1, 3'd2, 32'h0000_0102, 32'h1111_2222, 32'd0, 0, 0);
    do_access(1'b0, 1'b0, 3'd3, 32'h0000_0104, 32'd0, 32'h1234_5678, 0, 0);
    do_access(1'b0, 1'b1, 3'd4, 32'h0000_0104, 32'd0, 32'd0, 0, 0);
    do_access(1'b0, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'hDEAD_BEEF, 99, 0);
    do_access(1'b0, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'hDEAD_BEEF, 0, 3);
    do_access(1'b0, 1'b1, 3'd2, 32'h0000_0300, 32'h5555_AAAA, 32'd0, 99, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(2);
      fetch = (kind == 0);
      we = (kind == 2);
      f3 = 3'($urandom_range(7));
      a = $urandom();
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      gd = we ? $urandom_range(3) : $urandom_range(2);
      rv = $urandom_range(2);
      if ($urandom_range(9) == 0) gd = 99;
      do_access(fetch, we, f3, a, $urandom(), $urandom(), gd, rv);
    end

    reset_mid(1);
    reset_mid(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
